// File: rtl/bus_arb_pkg.sv
// Shared constants for the serial-bus arbiter: FSM state encodings and defaults.
// Latency: n/a (package only).
// Backpressure: n/a.
package bus_arb_pkg;

  // FSM state encodings; state_out exposes these values directly.
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_GRANT      = 3'd1;
  localparam logic [2:0] ST_ACTIVE     = 3'd2;
  localparam logic [2:0] ST_SLAVE_WAIT = 3'd3;
  localparam logic [2:0] ST_SLAVE_CMD  = 3'd4;
  localparam logic [2:0] ST_RESP       = 3'd5;
  localparam logic [2:0] ST_RELEASE    = 3'd6;

  // Width of the slave ID carried in the bus header.
  localparam int SID_WIDTH_DEF = 3;

  // arbiter_cmd is a single-cycle permission pulse; SLAVE_CMD lasts exactly this long.
  localparam int CMD_PULSE_CYCLES = 1;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first requester after 'last', searching upward with wrap-around.
// Latency: combinational.
// Backpressure: none; vld is low when no request is pending.
// Ports: req (request vector), last (index served most recently),
//        vld (some request present), idx (winning index).
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          vld,
  output logic [IW-1:0] idx
);

  always_comb begin
    int cand;
    cand = 0;
    vld  = 1'b0;
    idx  = '0;
    // Offsets 1..N put 'last' itself at the very end, so the previous owner
    // only wins again when nobody else is asking.
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      if (!vld && req[cand]) begin
        vld = 1'b1;
        idx = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Central arbiter for the shared serial bus: round-robin grant plus transaction phase tracking.
// Latency: grant registered 2 cycles after a request is seen in IDLE; arbiter_cmd 1 cycle after the target slave frees.
// Backpressure: holds in SLAVE_WAIT while the target slave is busy; optional watchdog (BUS_ARB_WATCHDOG_EN) forces release.
// Ports: clk/rstn (async active-low); m_req/m_handover/m_done/m_slave_id per master;
//        s_busy per slave; m_grant (one-hot), arbiter_cmd (one-hot pulse), bus_util, err_flag, state_out.
// Build option: define BUS_ARB_WATCHDOG_EN to build the per-phase watchdog.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 3,
  parameter int SID_WIDTH      = SID_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMER_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_MASTERS-1:0]         m_req,
  input  logic [NUM_MASTERS-1:0]         m_handover,
  input  logic [NUM_MASTERS-1:0]         m_done,
  input  logic [NUM_MASTERS*SID_WIDTH-1:0] m_slave_id,
  input  logic [NUM_SLAVES-1:0]          s_busy,
  output logic [NUM_MASTERS-1:0]         m_grant,
  output logic [NUM_SLAVES-1:0]          arbiter_cmd,
  output logic                           bus_util,
  output logic                           err_flag,
  output logic [2:0]                     state_out
);

  localparam int MIDX_W = $clog2(NUM_MASTERS);

  logic [2:0]             state, state_nxt;
  logic [MIDX_W-1:0]      win, last, pick_idx;
  logic                   pick_vld;
  logic [SID_WIDTH-1:0]   sid, pick_sid;
  logic                   sid_ok, slave_busy, set_err, wd_hit;
  logic [NUM_SLAVES-1:0]  cmd_onehot;
  logic [NUM_MASTERS-1:0] grant_onehot;
  logic                   own_done, own_handover;

  rr_priority_picker #(
    .N  (NUM_MASTERS),
    .IW (MIDX_W)
  ) u_picker (
    .req  (m_req),
    .last (last),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  // Only the owner's pulses matter; everyone else is ignored.
  assign own_done     = m_done[win];
  assign own_handover = m_handover[win];
  assign state_out    = state;

  always_comb begin
    pick_sid     = '0;
    grant_onehot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_idx == MIDX_W'(i)) pick_sid = m_slave_id[i*SID_WIDTH +: SID_WIDTH];
      grant_onehot[i] = (win == MIDX_W'(i));
    end
  end

  // Decode the latched slave ID; an ID with no matching slave leaves sid_ok low.
  always_comb begin
    sid_ok     = 1'b0;
    slave_busy = 1'b0;
    cmd_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sid == SID_WIDTH'(i)) begin
        sid_ok        = 1'b1;
        slave_busy    = s_busy[i];
        cmd_onehot[i] = 1'b1;
      end
    end
  end

`ifdef BUS_ARB_WATCHDOG_EN
  logic [TIMER_WIDTH-1:0] wd_cnt;
  logic                   wd_run;

  assign wd_run = (state == ST_ACTIVE) || (state == ST_SLAVE_WAIT) || (state == ST_RESP);
  // Fires on the TIMEOUT_CYCLES-th consecutive cycle spent in one waiting state.
  assign wd_hit = wd_run && (wd_cnt == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  wd_cnt <= '0;
    else if (state_nxt != state) wd_cnt <= '0;
    else if (wd_run)            wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    case (state)
      ST_IDLE:       if (pick_vld) state_nxt = ST_GRANT;
      ST_GRANT:      state_nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        // m_done wins over a simultaneous handover.
        if (own_done)          state_nxt = ST_RELEASE;
        else if (own_handover) state_nxt = ST_SLAVE_WAIT;
      end
      ST_SLAVE_WAIT: begin
        if (!sid_ok) begin
          state_nxt = ST_RELEASE;
          set_err   = 1'b1;
        end else if (!slave_busy) begin
          state_nxt = ST_SLAVE_CMD;
        end
      end
      ST_SLAVE_CMD:  state_nxt = ST_RESP;
      ST_RESP: begin
        if (own_done)          state_nxt = ST_RELEASE;
        else if (own_handover) state_nxt = ST_SLAVE_WAIT;
      end
      ST_RELEASE:    state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
    if (wd_hit) begin
      state_nxt = ST_RELEASE;
      set_err   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      win         <= '0;
      sid         <= '0;
      last        <= MIDX_W'(NUM_MASTERS - 1);
      m_grant     <= '0;
      arbiter_cmd <= '0;
      bus_util    <= 1'b1;
      err_flag    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && pick_vld) begin
        win <= pick_idx;
        sid <= pick_sid;
      end
      if (state == ST_GRANT) begin
        m_grant  <= grant_onehot;
        bus_util <= 1'b0;
      end
      // Drop the grant on entry to RELEASE so the bus reads free while state_out shows RELEASE.
      if (state_nxt == ST_RELEASE) begin
        m_grant  <= '0;
        bus_util <= 1'b1;
        last     <= win;
      end
      // Registered on entry so the pulse coincides exactly with the SLAVE_CMD state.
      arbiter_cmd <= (state_nxt == ST_SLAVE_CMD) ? cmd_onehot : '0;
      if (set_err) err_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] m_req, m_handover, m_done;
  logic [5:0] m_slave_id;
  logic [2:0] s_busy;
  logic [1:0] m_grant;
  logic [2:0] arbiter_cmd;
  logic       bus_util, err_flag;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_grant_q[$];
  logic [2:0] exp_cmd_q[$];

  bus_arbiter #(
    .NUM_MASTERS(2), .NUM_SLAVES(3), .SID_WIDTH(3), .TIMEOUT_CYCLES(16), .TIMER_WIDTH(8)
  ) dut (
    .clk(clk), .rstn(rstn), .m_req(m_req), .m_handover(m_handover), .m_done(m_done),
    .m_slave_id(m_slave_id), .s_busy(s_busy), .m_grant(m_grant), .arbiter_cmd(arbiter_cmd),
    .bus_util(bus_util), .err_flag(err_flag), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expectations are queued when stimulus is driven, popped when the DUT produces them.
  logic [1:0] prev_grant = '0;
  logic [2:0] prev_cmd   = '0;
  always @(negedge clk) begin
    if (rstn) begin
      chk("grant_onehot0", {31'd0, $onehot0(m_grant)}, 1);
      if (m_grant != 2'b00 && prev_grant == 2'b00) begin
        if (exp_grant_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_grant: actual=%b required=none", m_grant);
        end else chk("sb_grant", {30'd0, m_grant}, {30'd0, exp_grant_q.pop_front()});
      end
      if (arbiter_cmd != 3'b000) begin
        if (exp_cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_cmd: actual=%b required=none", arbiter_cmd);
        end else chk("sb_cmd", {29'd0, arbiter_cmd}, {29'd0, exp_cmd_q.pop_front()});
        chk("cmd_only_in_slave_cmd", {29'd0, state_out}, {29'd0, ST_SLAVE_CMD});
        chk("cmd_single_cycle", {29'd0, prev_cmd}, 0);
      end
    end
    prev_grant = m_grant;
    prev_cmd   = arbiter_cmd;
  end

  task automatic pulse(input logic [1:0] ho, input logic [1:0] dn);
    m_handover = ho;
    m_done     = dn;
    @(negedge clk);
    m_handover = '0;
    m_done     = '0;
  endtask

  task automatic wait_grant(input string name);
    int t = 0;
    while (m_grant == 2'b00 && t < 50) begin @(negedge clk); t++; end
    chk(name, {31'd0, m_grant != 2'b00}, 1);
  endtask

  task automatic wait_free(input string name);
    int t = 0;
    while (bus_util !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk(name, {31'd0, bus_util}, 1);
  endtask

  task automatic wait_state(input string name, input logic [2:0] st);
    int t = 0;
    while (state_out !== st && t < 50) begin @(negedge clk); t++; end
    chk(name, {29'd0, state_out}, {29'd0, st});
  endtask

  // mode: 0 done only, 1 handover/cmd/done, 2 handover+done same cycle, 3 handover to invalid ID
  typedef struct {
    logic [1:0] req;
    logic [5:0] sid;
    int         mode;
    int         busy;
    logic [1:0] egrant;
    logic [2:0] ecmd;
    logic       eerr;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int w;
    logic [2:0] tid, bmask;
    w     = v.egrant[1] ? 1 : 0;
    tid   = v.sid[w*3 +: 3];
    bmask = 3'b001 << tid;
    m_slave_id = v.sid;
    exp_grant_q.push_back(v.egrant);
    m_req = v.req;
    wait_grant("vec_grant_seen");
    chk("vec_bus_util_low", {31'd0, bus_util}, 0);
    case (v.mode)
      0: pulse(2'b00, 2'b01 << w);
      1: begin
        exp_cmd_q.push_back(v.ecmd);
        if (v.busy > 0) s_busy = bmask;
        pulse(2'b01 << w, 2'b00);
        for (int k = 0; k < v.busy; k++) begin
          @(negedge clk);
          chk("vec_cmd_held_busy", {29'd0, arbiter_cmd}, 0);
        end
        s_busy = 3'b000;
        @(negedge clk);
        chk("vec_cmd_pulse", {29'd0, arbiter_cmd}, {29'd0, v.ecmd});
        @(negedge clk);
        chk("vec_cmd_one_cycle", {29'd0, arbiter_cmd}, 0);
        pulse(2'b00, 2'b01 << w);
      end
      2: pulse(2'b01 << w, 2'b01 << w);
      default: pulse(2'b01 << w, 2'b00);
    endcase
    wait_free("vec_released");
    chk("vec_state_release", {29'd0, state_out}, {29'd0, ST_RELEASE});
    chk("vec_grant_cleared", {30'd0, m_grant}, 0);
    chk("vec_err_flag", {31'd0, err_flag}, {31'd0, v.eerr});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{2'b01, 6'o01, 1, 0, 2'b01, 3'b010, 1'b0};
    vecs[1] = '{2'b11, 6'o20, 1, 0, 2'b10, 3'b100, 1'b0};
    vecs[2] = '{2'b11, 6'o20, 1, 3, 2'b01, 3'b001, 1'b0};
    vecs[3] = '{2'b11, 6'o20, 1, 2, 2'b10, 3'b100, 1'b0};
    vecs[4] = '{2'b11, 6'o20, 0, 0, 2'b01, 3'b000, 1'b0};
    vecs[5] = '{2'b11, 6'o20, 2, 0, 2'b10, 3'b000, 1'b0};
    vecs[6] = '{2'b10, 6'o50, 3, 0, 2'b10, 3'b000, 1'b1};

    rstn = 1'b0; m_req = '0; m_handover = '0; m_done = '0; m_slave_id = '0; s_busy = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_grant", {30'd0, m_grant}, 0);
    chk("rst_cmd", {29'd0, arbiter_cmd}, 0);
    chk("rst_bus_util", {31'd0, bus_util}, 1);
    chk("rst_err", {31'd0, err_flag}, 0);
    chk("rst_state", {29'd0, state_out}, {29'd0, ST_IDLE});
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    m_req = 2'b00;

    // Non-owner pulses ignored, request drop ignored, multi-phase transaction.
    m_slave_id = 6'o21;
    exp_grant_q.push_back(2'b01);
    m_req = 2'b01;
    wait_grant("mp_grant_seen");
    m_req = 2'b00;
    pulse(2'b10, 2'b10);
    chk("mp_foreign_ignored", {29'd0, state_out}, {29'd0, ST_ACTIVE});
    chk("mp_grant_kept", {30'd0, m_grant}, 2'b01);
    exp_cmd_q.push_back(3'b010);
    exp_cmd_q.push_back(3'b010);
    pulse(2'b01, 2'b00);
    wait_state("mp_first_cmd", ST_SLAVE_CMD);
    @(negedge clk);
    chk("mp_resp", {29'd0, state_out}, {29'd0, ST_RESP});
    pulse(2'b01, 2'b00);
    wait_state("mp_second_cmd", ST_SLAVE_CMD);
    @(negedge clk);
    pulse(2'b00, 2'b01);
    wait_free("mp_released");
    chk("mp_err_sticky", {31'd0, err_flag}, 1);

    // Async reset while SLAVE_CMD is active.
    m_slave_id = 6'o20;
    exp_grant_q.push_back(2'b10);
    m_req = 2'b10;
    wait_grant("ar_grant_seen");
    m_req = 2'b00;
    exp_cmd_q.push_back(3'b100);
    pulse(2'b10, 2'b00);
    wait_state("ar_in_slave_cmd", ST_SLAVE_CMD);
    #2 rstn = 1'b0;
    #1;
    chk("ar_cmd_cleared", {29'd0, arbiter_cmd}, 0);
    chk("ar_grant_cleared", {30'd0, m_grant}, 0);
    chk("ar_bus_util", {31'd0, bus_util}, 1);
    chk("ar_err_cleared", {31'd0, err_flag}, 0);
    @(negedge clk);
    rstn = 1'b1;
    exp_grant_q.push_back(2'b01);
    m_req = 2'b11;
    wait_grant("ar_regrant_seen");
    m_req = 2'b00;
    pulse(2'b00, 2'b01);
    wait_free("ar_released");

    // Master 1 owns the bus and never finishes.
    exp_grant_q.push_back(2'b10);
    m_req = 2'b10;
    wait_grant("wd_grant_seen");
    m_req = 2'b00;
`ifdef BUS_ARB_WATCHDOG_EN
    repeat (15) @(negedge clk);
    chk("wd_still_active", {29'd0, state_out}, {29'd0, ST_ACTIVE});
    chk("wd_no_err_yet", {31'd0, err_flag}, 0);
    @(negedge clk);
    chk("wd_err", {31'd0, err_flag}, 1);
    chk("wd_grant_cleared", {30'd0, m_grant}, 0);
    chk("wd_bus_util", {31'd0, bus_util}, 1);
    chk("wd_state_release", {29'd0, state_out}, {29'd0, ST_RELEASE});
`else
    repeat (20) @(negedge clk);
    chk("nowd_still_active", {29'd0, state_out}, {29'd0, ST_ACTIVE});
    chk("nowd_no_err", {31'd0, err_flag}, 0);
    chk("nowd_grant_kept", {30'd0, m_grant}, 2'b10);
    pulse(2'b00, 2'b10);
    wait_free("nowd_released");
`endif
    repeat (4) @(negedge clk);
    chk("sb_grant_drained", exp_grant_q.size(), 0);
    chk("sb_cmd_drained", exp_cmd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central controller for the shared single-wire serial data bus.
- Grants the bus to one of NUM_MASTERS masters using round-robin order.
- Tracks each transaction's phases: master drive, handover to the target slave, slave response, release.
- Issues the per-slave arbiter_cmd permission pulse that slaves wait for before driving data or ack. Drives bus_util, which parked slaves use to return to idle.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
NUM_SLAVES, 3, number of slaves (1..8); slave IDs are 0..NUM_SLAVES-1
SID_WIDTH, 3, width of the slave ID carried in the bus header
TIMEOUT_CYCLES, 255, watchdog limit per phase, in clk cycles
TIMER_WIDTH, 8, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
m_req  in  NUM_MASTERS  level request per master
m_handover  in  NUM_MASTERS  1-cycle pulse: master finished its header/data drive and awaits the slave
m_done  in  NUM_MASTERS  1-cycle pulse: master finished the transaction and releases the bus
m_slave_id  in  NUM_MASTERS*SID_WIDTH  packed target slave ID; master i uses bits [i*SID_WIDTH +: SID_WIDTH]
s_busy  in  NUM_SLAVES  slave busy_out lines
m_grant  out  NUM_MASTERS  registered one-hot grant
arbiter_cmd  out  NUM_SLAVES  registered one-hot 1-cycle pulse permitting a slave to transmit
bus_util  out  1  high when no transaction owns the bus
err_flag  out  1  sticky; set on watchdog expiry or invalid slave ID
state_out  out  3  current FSM state

Behaviour:
- Reset (async, rstn=0):
  - m_grant=0, arbiter_cmd=0, bus_util=1, err_flag=0, state=IDLE, watchdog=0.
  - Round-robin pointer last=NUM_MASTERS-1, so master 0 wins first.
  - Reset mid-transaction aborts immediately; no release pulse follows.
- States (encoded in package): IDLE=0, GRANT=1, ACTIVE=2, SLAVE_WAIT=3, SLAVE_CMD=4, RESP=5, RELEASE=6.
- IDLE:
  - bus_util=1.
  - If any m_req is high, pick the first requester searching last+1, last+2, ... with wrap-around. Latch the winner index w, its slave ID, and go to GRANT.
- GRANT:
  - m_grant[w]=1 and bus_util=0, both registered; the grant is visible 2 cycles after m_req rises in IDLE.
  - Clear the watchdog and go to ACTIVE.
- ACTIVE:
  - m_done[w] goes to RELEASE. It takes priority if m_handover[w] is asserted in the same cycle.
  - Otherwise m_handover[w] goes to SLAVE_WAIT.
  - Pulses from non-granted masters are ignored.
- SLAVE_WAIT:
  - If the latched ID is >= NUM_SLAVES: set err_flag and go to RELEASE.
  - If s_busy[id]=0: go to SLAVE_CMD.
  - Otherwise hold.
- SLAVE_CMD:
  - arbiter_cmd[id]=1 for exactly one cycle, then go to RESP.
- RESP:
  - m_done[w] goes to RELEASE.
  - A second m_handover[w] (multi-phase transaction) returns to SLAVE_WAIT.
- RELEASE:
  - m_grant=0, bus_util=1, last=w; go to IDLE next cycle.
  - A master still holding m_req can be re-granted only after all other requesters have been served.
- Watchdog (feature-gated):
  - Counts in ACTIVE, SLAVE_WAIT and RESP; clears on every state change.
  - On reaching TIMEOUT_CYCLES: err_flag=1, go to RELEASE.
- m_req dropping while granted has no effect; only m_done or the watchdog ends ownership.
- Only m_grant[w] is ever high, and arbiter_cmd is never high outside SLAVE_CMD.

Optional Feature:
BUS_ARB_WATCHDOG_EN
- Defined: the watchdog counter and the timeout transitions are present, as specified above.
- Undefined: no counter is built and states wait indefinitely. err_flag is then set only by an invalid slave ID.

Decomposition:
- Package bus_arb_pkg holds the state localparams, SID_WIDTH default, and the arbiter_cmd pulse width (1).
- Sub-module rr_priority_picker is natural: combinational; inputs are the request vector and last index; outputs are a grant-valid bit and the winner index.

Test Plan:
- Single request: m_req=2'b01 in IDLE -> m_grant=01 two cycles later, bus_util=0; m_done[0] -> RELEASE, then m_grant=00, bus_util=1.
- Round-robin fairness: m_req=2'b11 held constant -> grants alternate 01,10,01,10 across four transactions.
- Slave handshake: master 1 targets ID 2, handover while s_busy=3'b100 -> no arbiter_cmd; s_busy drops -> arbiter_cmd=3'b100 for exactly 1 cycle next cycle.
- Invalid ID: m_slave_id=5 with NUM_SLAVES=3, handover -> err_flag=1, arbiter_cmd stays 0, bus released.
- Watchdog: granted master never pulses m_done, TIMEOUT_CYCLES=16 -> after 16 ACTIVE cycles err_flag=1, m_grant=0, bus_util=1.
- Async reset during SLAVE_CMD -> arbiter_cmd and m_grant go to 0 immediately, bus_util=1; master 0 wins the next arbitration.
